// File: rtl/shifter_pkg.sv
// Shared types for the parameterised shifter: command encoding, FSM states
// and the helper that classifies which opcodes take the multi-cycle path.
// Optional feature macro: PARAM_SHIFTER_ROTATE_EN (enables ROR/ROL).
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHR  = 3'b010,
        OP_SHL  = 3'b011,
        OP_ASR  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Opcodes that walk through the SHW shift cycles; everything else
    // (NOP, LOAD, reserved, and rotates when disabled) finishes in one cycle.
    function automatic logic is_shift_op(op_e op);
        case (op)
            OP_SHR, OP_SHL, OP_ASR: return 1'b1;
`ifdef PARAM_SHIFTER_ROTATE_EN
            OP_ROR, OP_ROL:         return 1'b1;
`endif
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/param_shifter_if.sv
// Command/result bundle of the parameterised shifter. The master drives a
// command, the slave (the shifter) reports readiness, the accumulator value
// and the one-cycle completion pulse.
interface param_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [SHW-1:0]   shiftnum;
    logic             inbit;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, shiftnum, inbit, in,
        input  cmd_ready, out, done
    );

    modport slave (
        input  cmd_valid, cmd_op, shiftnum, inbit, in,
        output cmd_ready, out, done
    );

endinterface

// File: rtl/shift_stage.sv
// One conditional power-of-two shift stage. The same hardware is reused on
// every SHIFT cycle: the stage index input selects the 2^k distance, and
// the enable (shift-amount bit k) decides whether the data moves at all.
// Optional feature macro: PARAM_SHIFTER_ROTATE_EN (adds the rotate paths).
module shift_stage
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  op_e              op,
    input  logic [SHW-1:0]   stage,
    input  logic             en,
    input  logic             fill,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] fill_mask_r;
    logic [WIDTH-1:0] fill_mask_l;
`ifdef PARAM_SHIFTER_ROTATE_EN
    logic [SHW:0]     rot_back;
`endif

    // Shift/rotate the data by 2^stage when enabled, else pass it through.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        amt         = SHW'(1) << stage;
        fill_mask_r = ~({WIDTH{1'b1}} >> amt);
        fill_mask_l = ~({WIDTH{1'b1}} << amt);
`ifdef PARAM_SHIFTER_ROTATE_EN
        rot_back    = (SHW+1)'(WIDTH) - {1'b0, amt};
`endif
        dout        = din;
        if (en) begin
            case (op)
                OP_SHR, OP_ASR: dout = (din >> amt) | ({WIDTH{fill}} & fill_mask_r);
                OP_SHL:         dout = (din << amt) | ({WIDTH{fill}} & fill_mask_l);
`ifdef PARAM_SHIFTER_ROTATE_EN
                OP_ROR:         dout = (din >> amt) | (din << rot_back);
                OP_ROL:         dout = (din << amt) | (din >> rot_back);
`endif
                default:        dout = din;
            endcase
        end
    end

endmodule

// File: rtl/param_shifter.sv
// Multi-cycle barrel shifter with an accumulator register. Shifts take a
// fixed SHW+1 cycles (one log-step per cycle) whatever the shift amount;
// LOAD/NOP/reserved finish one cycle after acceptance.
// Optional feature macro: PARAM_SHIFTER_ROTATE_EN (ROR/ROL; otherwise NOPs).
module param_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    param_shifter_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q;
    state_e           state_d;
    op_e              cmd_op;
    op_e              op_q;
    logic [SHW-1:0]   num_q;
    logic             fill_q;
    logic [SHW-1:0]   stage_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] stage_out;
    logic             accept;
    logic             last_stage;

    assign cmd_op     = op_e'(bus.cmd_op);
    assign accept     = bus.cmd_valid && bus.cmd_ready;
    assign last_stage = (stage_q == SHW'(SHW - 1));
    assign bus.out    = acc_q;

    // State register; synchronous reset returns to IDLE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: IDLE -> SHIFT (SHW cycles) or straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = is_shift_op(cmd_op) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (last_stage) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state only.
    always_comb begin
        bus.cmd_ready = (state_q == ST_IDLE);
        bus.done      = (state_q == ST_DONE);
    end

    // Command capture and accumulator update.
    always_ff @(posedge clk) begin
        // NOTE: the captured command fields are plain registers, reset alongside the accumulator so nothing is ever X.
        if (rst) begin
            acc_q   <= '0;
            op_q    <= OP_NOP;
            num_q   <= '0;
            fill_q  <= 1'b0;
            stage_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= cmd_op;
                        num_q   <= bus.shiftnum;
                        // ASR fills with the sign of the value at acceptance.
                        fill_q  <= (cmd_op == OP_ASR) ? acc_q[WIDTH-1] : bus.inbit;
                        stage_q <= '0;
                        if (cmd_op == OP_LOAD) acc_q <= bus.in;
                    end
                end
                ST_SHIFT: begin
                    acc_q   <= stage_out;
                    stage_q <= stage_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    shift_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .op    (op_q),
        .stage (stage_q),
        .en    (num_q[stage_q]),
        .fill  (fill_q),
        .din   (acc_q),
        .dout  (stage_out)
    );

endmodule
